// File: rtl/day015_ram_burst_ctrl.sv
// day015_ram_burst_ctrl: burst initiator for one port of a 1-cycle-latency synchronous RAM.
// Optional beat counters wr_beats_o/rd_beats_o are added when RAM_BURST_STATS_EN is defined.
module day015_ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
`ifdef RAM_BURST_STATS_EN
  ,
  output logic [15:0]           wr_beats_o,
  output logic [15:0]           rd_beats_o
`endif
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_d, remaining, remaining_d, len_clamped, addr_inc;
  logic rd_pending, rd_pending_d, done, done_d, wr_beat, last;
  assign len_clamped = ({1'b0, cmd_len_i} >= (ADDR_WIDTH+1)'(DEPTH)) ? ADDR_WIDTH'(DEPTH - 1) : cmd_len_i;
  assign addr_inc = (cur_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_addr + ADDR_WIDTH'(1);
  assign wr_beat = (state == WRITE) && wdata_valid_i;
  assign last = (remaining == '0);
  assign cmd_ready_o = (state == IDLE);
  assign wdata_ready_o = (state == WRITE);
  assign ram_we_o = wr_beat;
  assign ram_addr_o = cur_addr;
  assign ram_data_o = wdata_i;
  assign rdata_valid_o = rd_pending;
  assign rdata_o = ram_data_i;
  assign done_o = done;
  // Reads issue one address per cycle; writes advance only on accepted beats.
  always_comb begin
    state_d = state;
    cur_addr_d = cur_addr;
    remaining_d = remaining;
    rd_pending_d = 1'b0;
    done_d = 1'b0;
    if ((state == IDLE) && cmd_valid_i) begin
      cur_addr_d = cmd_addr_i;
      remaining_d = len_clamped;
      state_d = cmd_write_i ? WRITE : READ;
    end else if (wr_beat || (state == READ)) begin
      cur_addr_d = addr_inc;
      remaining_d = last ? '0 : remaining - ADDR_WIDTH'(1);
      rd_pending_d = (state == READ);
      done_d = last;
      state_d = last ? IDLE : state;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      rd_pending <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      cur_addr <= cur_addr_d;
      remaining <= remaining_d;
      rd_pending <= rd_pending_d;
      done <= done_d;
    end
  end
`ifdef RAM_BURST_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_beats_o <= '0;
      rd_beats_o <= '0;
    end else begin
      if (wr_beat && (wr_beats_o != 16'hFFFF)) wr_beats_o <= wr_beats_o + 16'd1;
      if (rd_pending && (rd_beats_o != 16'hFFFF)) rd_beats_o <= rd_beats_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_day015_ram_burst_ctrl.sv
// tb_day015_ram_burst_ctrl: directed bench for the burst controller with a behavioural 1-cycle RAM.
module tb_day015_ram_burst_ctrl;
  logic clk = 1'b0;
  logic rst_ni;
  logic cmd_valid, cmd_ready_o, cmd_write, wdata_valid, wdata_ready_o;
  logic rdata_valid_o, done_o, ram_we_o;
  logic [2:0] cmd_addr, cmd_len, ram_addr_o;
  logic [7:0] wdata, rdata_o, ram_data_o, ram_rdata;
  logic [7:0] mem [8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  day015_ram_burst_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_data_o(ram_data_o), .ram_data_i(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
    ram_rdata <= mem[ram_addr_o];
  end

  // Drives a write burst (beat k carries d0+k, gap idle cycles between beats); returns at done_o.
  task automatic write_burst(input logic [2:0] a, input logic [2:0] l, input logic [7:0] d0, input int gap,
                             input bit hold_rd, input logic [2:0] ra, input logic [2:0] rl,
                             output int we_n, output int done_n, output int lag, output int addr_err);
    int k, wait_n, last_c, beats;
    beats = int'(l) + 1; k = 0; wait_n = 0; last_c = -10;
    we_n = 0; done_n = 0; lag = -1; addr_err = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = l; wdata_valid = 0;
    @(negedge clk);
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      cmd_valid = hold_rd; cmd_write = 0; cmd_addr = ra; cmd_len = rl;
      if (k < beats && wait_n == 0) begin
        wdata_valid = 1; wdata = d0 + 8'(k);
      end else begin
        wdata_valid = 0;
        if (wait_n > 0) wait_n--;
      end
      @(negedge clk);
      if (ram_we_o) begin
        we_n++;
        if (ram_addr_o !== 3'(int'(a) + k)) addr_err++;
      end
      if (wdata_valid && wdata_ready_o) begin
        k++; last_c = t; wait_n = (k < beats) ? gap : 0;
      end
      if (done_o) begin
        done_n++; lag = t - last_c;
        break;
      end
    end
  endtask

  // Collects a read burst; t=1 is the first address cycle. Data shifts into dv, oldest beat highest.
  task automatic read_burst(input bit issue, input logic [2:0] a, input logic [2:0] l,
                            output logic [63:0] dv, output int n, output int first_c, output int last_c,
                            output int done_n, output bit done_last, output logic [2:0] addr1);
    dv = '0; n = 0; first_c = -1; last_c = -1; done_n = 0; done_last = 0; addr1 = 'x;
    if (issue) begin
      @(posedge clk); #1;
      cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l;
      @(negedge clk);
    end
    for (int t = 1; t < 30; t++) begin
      @(posedge clk); #1;
      cmd_valid = 0; wdata_valid = 0;
      @(negedge clk);
      if (t == 1) addr1 = ram_addr_o;
      if (rdata_valid_o) begin
        dv = {dv[55:0], rdata_o}; n++;
        if (first_c < 0) first_c = t;
        last_c = t;
      end
      if (done_o) begin
        done_n++; done_last = rdata_valid_o && (n == int'(l) + 1);
        break;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    cmd_valid = 0; wdata_valid = 0;
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL %s_no_extra_done got=%b exp=0", tag, done_o); end
    checks++; if (rdata_valid_o !== 1'b0) begin failures++; $display("FAIL %s_no_extra_rvalid got=%b exp=0", tag, rdata_valid_o); end
  endtask

  task automatic test_reset;
    rst_ni = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; wdata_valid = 1; wdata = 8'hAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready_o); end
    checks++; if (wdata_ready_o !== 1'b0) begin failures++; $display("FAIL rst_wdata_ready got=%b exp=0", wdata_ready_o); end
    checks++; if (ram_we_o !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we_o); end
    checks++; if (ram_addr_o !== 3'd0) begin failures++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (rdata_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", rdata_valid_o); end
    @(posedge clk); #1;
    rst_ni = 1; wdata_valid = 0;
  endtask

  task automatic test_write;
    int we_n, done_n, lag, addr_err;
    write_burst(3'd2, 3'd3, 8'd1, 0, 0, 3'd0, 3'd0, we_n, done_n, lag, addr_err);
    checks++; if (we_n !== 4) begin failures++; $display("FAIL wr_we_count got=%0d exp=4", we_n); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL wr_addr_errors got=%0d exp=0", addr_err); end
    checks++; if (done_n !== 1 || lag !== 1) begin failures++; $display("FAIL wr_done done=%0d lag=%0d exp done=1 lag=1", done_n, lag); end
    idle_check("wr");
    checks++; if ({mem[2], mem[3], mem[4], mem[5]} !== 32'h01020304) begin failures++; $display("FAIL wr_mem got=%h exp=01020304", {mem[2], mem[3], mem[4], mem[5]}); end
  endtask

  task automatic test_read;
    logic [63:0] dv; int n, fc, lc, dn; bit dl; logic [2:0] a1;
    read_burst(1, 3'd2, 3'd3, dv, n, fc, lc, dn, dl, a1);
    checks++; if (a1 !== 3'd2) begin failures++; $display("FAIL rd_first_addr got=%0d exp=2", a1); end
    checks++; if (n !== 4 || dv[31:0] !== 32'h01020304) begin failures++; $display("FAIL rd_data n=%0d got=%h exp n=4 data=01020304", n, dv[31:0]); end
    checks++; if (fc !== 2 || lc !== 5) begin failures++; $display("FAIL rd_timing first=%0d last=%0d exp first=2 last=5", fc, lc); end
    checks++; if (dn !== 1 || dl !== 1'b1) begin failures++; $display("FAIL rd_done done=%0d with_last=%b exp 1/1", dn, dl); end
    idle_check("rd");
  endtask

  task automatic test_wrap;
    int we_n, done_n, lag, addr_err;
    logic [63:0] dv; int n, fc, lc, dn; bit dl; logic [2:0] a1;
    write_burst(3'd6, 3'd3, 8'd9, 0, 0, 3'd0, 3'd0, we_n, done_n, lag, addr_err);
    checks++; if (we_n !== 4 || addr_err !== 0) begin failures++; $display("FAIL wrap_wr we=%0d addr_err=%0d exp 4/0", we_n, addr_err); end
    checks++; if ({mem[6], mem[7], mem[0], mem[1]} !== 32'h090a0b0c) begin failures++; $display("FAIL wrap_mem got=%h exp=090a0b0c", {mem[6], mem[7], mem[0], mem[1]}); end
    read_burst(1, 3'd6, 3'd3, dv, n, fc, lc, dn, dl, a1);
    checks++; if (n !== 4 || dv[31:0] !== 32'h090a0b0c) begin failures++; $display("FAIL wrap_rd n=%0d got=%h exp n=4 data=090a0b0c", n, dv[31:0]); end
    checks++; if (dn !== 1 || dl !== 1'b1) begin failures++; $display("FAIL wrap_rd_done done=%0d with_last=%b exp 1/1", dn, dl); end
  endtask

  task automatic test_reset_mid_burst;
    logic [63:0] dv; int n, fc, lc, dn; bit dl; logic [2:0] a1;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd2; cmd_len = 3'd3;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_ni = 0;
    @(negedge clk);
    checks++; if (rdata_valid_o !== 1'b1 || rdata_o !== 8'd1) begin failures++; $display("FAIL rstmid_beat1 v=%b d=%0d exp v=1 d=1", rdata_valid_o, rdata_o); end
    @(posedge clk); #1;
    rst_ni = 1;
    @(negedge clk);
    checks++; if (rdata_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid got=%b exp=0", rdata_valid_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done_o); end
    checks++; if (cmd_ready_o !== 1'b1 || ram_addr_o !== 3'd0) begin failures++; $display("FAIL rstmid_idle ready=%b addr=%0d exp 1/0", cmd_ready_o, ram_addr_o); end
    idle_check("rstmid");
    read_burst(1, 3'd6, 3'd3, dv, n, fc, lc, dn, dl, a1);
    checks++; if (n !== 4 || dv[31:0] !== 32'h090a0b0c || dn !== 1 || dl !== 1'b1) begin failures++; $display("FAIL rstmid_after n=%0d data=%h done=%0d last=%b exp 4/090a0b0c/1/1", n, dv[31:0], dn, dl); end
  endtask

  task automatic test_stall;
    int we_n, done_n, lag, addr_err;
    write_burst(3'd3, 3'd2, 8'h20, 2, 0, 3'd0, 3'd0, we_n, done_n, lag, addr_err);
    checks++; if (we_n !== 3) begin failures++; $display("FAIL stall_we_count got=%0d exp=3", we_n); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL stall_addr_errors got=%0d exp=0", addr_err); end
    checks++; if (done_n !== 1 || lag !== 1) begin failures++; $display("FAIL stall_done done=%0d lag=%0d exp 1/1", done_n, lag); end
    checks++; if ({mem[2], mem[3], mem[4], mem[5], mem[6]} !== 40'h0120212209) begin failures++; $display("FAIL stall_mem got=%h exp=0120212209", {mem[2], mem[3], mem[4], mem[5], mem[6]}); end
    idle_check("stall");
  endtask

  task automatic test_back_to_back;
    int we_n, done_n, lag, addr_err;
    logic [63:0] dv; int n, fc, lc, dn; bit dl; logic [2:0] a1;
    write_burst(3'd4, 3'd1, 8'h30, 0, 1, 3'd4, 3'd1, we_n, done_n, lag, addr_err);
    checks++; if (we_n !== 2 || done_n !== 1) begin failures++; $display("FAIL b2b_write we=%0d done=%0d exp 2/1", we_n, done_n); end
    checks++; if (cmd_ready_o !== 1'b1 || cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_accept_in_done ready=%b exp=1", cmd_ready_o); end
    read_burst(0, 3'd4, 3'd1, dv, n, fc, lc, dn, dl, a1);
    checks++; if (a1 !== 3'd4) begin failures++; $display("FAIL b2b_first_addr got=%0d exp=4", a1); end
    checks++; if (n !== 2 || dv[15:0] !== 16'h3031) begin failures++; $display("FAIL b2b_data n=%0d got=%h exp n=2 data=3031", n, dv[15:0]); end
    checks++; if (fc !== 2 || dn !== 1 || dl !== 1'b1) begin failures++; $display("FAIL b2b_timing first=%0d done=%0d last=%b exp 2/1/1", fc, dn, dl); end
    idle_check("b2b");
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_reset_mid_burst;
    test_stall;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
